planificador_rango: RTL and testbench

Sequential scheduler that shares one signed 5-bit window comparator among four requesters. Each requester has its own programmable limit pair. Each check is a three-state FSM pass: a request is granted round-robin, the sample is captured, its window is compared, and a one-cycle result is returned. It sits between the per-lane sample sources and the single range-check datapath, and it also keeps a saturating count of in-window hits.

---
 rtl/rango_pkg.sv | 18 +
 rtl/comparador_ventana.sv | 18 +
 rtl/planificador_rango.sv | 168 ++++++++++++++++
 tb/tb_planificador_rango.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rango_pkg.sv
// Shared types and constants for the windowed range-check scheduler.
package rango_pkg;

    localparam int W     = 5;
    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPARA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    // Reset window covers the whole signed 5-bit range.
    localparam logic signed [W-1:0] INF_RST = 5'b10000;
    localparam logic signed [W-1:0] SUP_RST = 5'b01111;
    localparam logic [7:0]          CNT_MAX = 8'd255;

endpackage

// File: rtl/comparador_ventana.sv
// Combinational signed window comparator; the single resource shared by all lanes.
module comparador_ventana #(
    parameter int W = rango_pkg::W
) (
    input  logic signed [W-1:0] num,
    input  logic signed [W-1:0] inf,
    input  logic signed [W-1:0] sup,
    output logic                dentro,
    output logic                invalido
);

    // An inverted window never reports a hit.
    always_comb begin
        invalido = (inf > sup);
        dentro   = !invalido && (num >= inf) && (num <= sup);
    end

endmodule

// File: rtl/planificador_rango.sv
// Round-robin scheduler of four requesters onto one window comparator,
// one check every three cycles, with a saturating hit counter.
module planificador_rango #(
    parameter int W     = rango_pkg::W,
    parameter int N_REQ = rango_pkg::N_REQ
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_sel,
    input  logic [W-1:0]         cfg_inf,
    input  logic [W-1:0]         cfg_sup,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   numero,
    output logic [N_REQ-1:0]     gnt,
    output logic                 resp_valid,
    output logic [1:0]           resp_id,
    output logic                 dentro,
    output logic                 err_cfg,
    input  logic                 clr_cnt,
    output logic [7:0]           cnt_dentro
);

    import rango_pkg::*;

    estado_t state_reg, state_next;

    logic [1:0]          ptr_reg;
    logic [N_REQ-1:0]    gnt_reg;
    logic [1:0]          id_reg;
    logic signed [W-1:0] num_snap_reg, inf_snap_reg, sup_snap_reg;
    logic                resp_valid_reg;
    logic [1:0]          resp_id_reg;
    logic                dentro_reg;
    logic                err_reg;
    logic [7:0]          cnt_reg;

    logic [N_REQ*W-1:0]  inf_flat, sup_flat;

    logic                sel_found;
    logic [1:0]          sel_id;
    logic [1:0]          cand;
    logic signed [W-1:0] num_sel, inf_sel, sup_sel;
    logic                cmp_dentro, cmp_invalido;

    // Per-lane limit registers, writable in any state.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            logic signed [W-1:0] inf_reg, sup_reg;

            // Limit pair of this lane; a write lands on the next edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    inf_reg <= INF_RST;
                    sup_reg <= SUP_RST;
                end else if (cfg_we && (cfg_sel == 2'(gi))) begin
                    inf_reg <= cfg_inf;
                    sup_reg <= cfg_sup;
                end
            end

            assign inf_flat[gi*W +: W] = inf_reg;
            assign sup_flat[gi*W +: W] = sup_reg;
        end
    endgenerate

    // Round-robin pick: first requesting lane at or after the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = ptr_reg;
        cand      = ptr_reg;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_reg + 2'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    assign num_sel = numero[sel_id*W +: W];
    assign inf_sel = inf_flat[sel_id*W +: W];
    assign sup_sel = sup_flat[sel_id*W +: W];

    // The comparator only ever sees the snapshots, so config writes mid-check are harmless.
    comparador_ventana #(.W(W)) u_comparador (
        .num      (num_snap_reg),
        .inf      (inf_snap_reg),
        .sup      (sup_snap_reg),
        .dentro   (cmp_dentro),
        .invalido (cmp_invalido)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: grant, compare, respond, back to idle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (sel_found) state_next = COMPARA;
            COMPARA:  state_next = RESPONDE;
            RESPONDE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Grant, snapshot and result registers driven by the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg        <= '0;
            gnt_reg        <= '0;
            id_reg         <= '0;
            num_snap_reg   <= '0;
            inf_snap_reg   <= '0;
            sup_snap_reg   <= '0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            dentro_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            gnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        gnt_reg      <= N_REQ'(1) << sel_id;
                        id_reg       <= sel_id;
                        num_snap_reg <= num_sel;
                        inf_snap_reg <= inf_sel;
                        sup_snap_reg <= sup_sel;
                        ptr_reg      <= sel_id + 2'd1;
                    end
                end
                COMPARA: begin
                    resp_valid_reg <= 1'b1;
                    resp_id_reg    <= id_reg;
                    dentro_reg     <= cmp_dentro;
                    err_reg        <= cmp_invalido;
                end
                default: ;
            endcase
        end
    end

    // Saturating hit counter; clear has priority over a coincident hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (resp_valid_reg && dentro_reg && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign gnt        = gnt_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign dentro     = dentro_reg;
    assign err_cfg    = err_reg;
    assign cnt_dentro = cnt_reg;

endmodule

// File: tb/tb_planificador_rango.sv
// Scoreboard bench: stimulus queues expected results, a monitor checks each response.
module tb_planificador_rango;

    localparam int W = 5;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [1:0]     cfg_sel;
    logic [W-1:0]   cfg_inf, cfg_sup;
    logic [N-1:0]   req;
    logic [N*W-1:0] numero;
    logic [N-1:0]   gnt;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic           dentro;
    logic           err_cfg;
    logic           clr_cnt;
    logic [7:0]     cnt_dentro;

    typedef struct {
        logic [1:0] id;
        logic       d;
        logic       e;
        logic       clr;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    int   cyc = 0;

    planificador_rango dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_inf    (cfg_inf),
        .cfg_sup    (cfg_sup),
        .req        (req),
        .numero     (numero),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .dentro     (dentro),
        .err_cfg    (err_cfg),
        .clr_cnt    (clr_cnt),
        .cnt_dentro (cnt_dentro)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per response, checks the count one cycle later.
    initial begin
        exp_t e;
        bit   cnt_chk;
        cnt_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt_chk) begin
                cnt_chk = 1'b0;
                check("cnt_dentro", int'(cnt_dentro), exp_cnt);
            end
            if (!reset && resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("resp id=%0d dentro=%0d err=%0d (exp id=%0d dentro=%0d err=%0d)",
                             resp_id, dentro, err_cfg, e.id, e.d, e.e);
                    check("resp_id", int'(resp_id), int'(e.id));
                    check("dentro", int'(dentro), int'(e.d));
                    check("err_cfg", int'(err_cfg), int'(e.e));
                    if (e.clr)                      exp_cnt = 0;
                    else if (e.d && exp_cnt < 255)  exp_cnt = exp_cnt + 1;
                    cnt_chk = 1'b1;
                end
            end
        end
    end

    task automatic set_num(input int lane, input int val);
        logic [W-1:0] v;
        v = W'(val);
        numero[lane*W +: W] = v;
    endtask

    task automatic cfg(input int lane, input int lo, input int hi);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_sel = 2'(lane);
        cfg_inf = W'(lo);
        cfg_sup = W'(hi);
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    // Waits for any grant with a cycle budget; returns 0 on timeout.
    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 0, 1);
    endtask

    // One check on one lane; optional limit write right after the grant and optional clear.
    task automatic issue(input int lane, input int val, input bit d, input bit e,
                         input bit wr, input int wlo, input int whi, input bit clr);
        exp_t x;
        bit   ok;
        logic [N-1:0] one;
        @(negedge clk);
        set_num(lane, val);
        req[lane] = 1'b1;
        x.id = 2'(lane); x.d = d; x.e = e; x.clr = clr;
        sb.push_back(x);
        wait_gnt(ok);
        one = N'(1) << lane;
        if (ok) check("gnt_onehot", int'(gnt), int'(one));
        req[lane] = 1'b0;
        if (wr) begin
            cfg_we  = 1'b1;
            cfg_sel = 2'(lane);
            cfg_inf = W'(wlo);
            cfg_sup = W'(whi);
        end
        if (clr) clr_cnt = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    initial begin
        bit  ok;
        int  prev;
        bit  seen;
        exp_t x;
        logic [N-1:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_inf = '0; cfg_sup = '0;
        req = '0; numero = '0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_id", int'(resp_id), 0);
        check("rst_dentro", int'(dentro), 0);
        check("rst_err_cfg", int'(err_cfg), 0);
        check("rst_cnt", int'(cnt_dentro), 0);
        reset = 1'b0;
        @(negedge clk);

        // Default window accepts the most negative sample.
        issue(2, -16, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        // Narrow negative window on lane 0.
        cfg(0, -5, -2);
        issue(0, -3, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        issue(0, -1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        issue(0,  4, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Serve lane 3 so the pointer wraps to lane 0, then hold all requests.
        issue(3, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        set_num(0, -3); set_num(1, 0); set_num(2, 0); set_num(3, 0);
        for (int i = 0; i < 5; i++) begin
            x.id = (i == 4) ? 2'd0 : 2'(i); x.d = 1'b1; x.e = 1'b0; x.clr = 1'b0;
            sb.push_back(x);
        end
        req = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(ok);
            if (!ok) break;
            check("rr_gnt", int'(gnt), int'(order[i]));
            if (i > 0) check("rr_spacing", cyc - prev, 3);
            prev = cyc;
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Inverted window reports an error and never a hit.
        cfg(1, 3, -3);
        issue(1, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

        // Limit write during a check only affects later checks.
        issue(0, -3, 1'b1, 1'b0, 1'b1, 0, 5, 1'b0);
        issue(0, -3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        issue(0,  3, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        // Drive the counter into saturation.
        for (int i = 0; i < 260; i++) issue(3, 5, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        check("cnt_saturated", int'(cnt_dentro), 255);

        // Clear coinciding with a hit wins.
        issue(3, 5, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);

        // Reset while the comparison is pending.
        @(negedge clk);
        set_num(3, 0);
        req[3] = 1'b1;
        wait_gnt(ok);
        req[3] = 1'b0;
        reset = 1'b1;
        exp_cnt = 0;
        #1;
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_resp_valid", int'(resp_valid), 0);
        check("midrst_resp_id", int'(resp_id), 0);
        check("midrst_dentro", int'(dentro), 0);
        check("midrst_err_cfg", int'(err_cfg), 0);
        check("midrst_cnt", int'(cnt_dentro), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("midrst_no_resp", int'(seen), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
